// File: rtl/bus_pkg.sv
// Shared types and constants for the instruction/data bus arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which client owns (or last owned) the master port
//   ABORT_RDATA : read data returned to a client whose transfer timed out
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D
   } arb_state_t;

   typedef enum logic {
      INSTR,
      DATA
   } grant_t;

   localparam logic [31:0] ABORT_RDATA = 32'h0;

endpackage

// File: rtl/bus_watchdog.sv
// Wait-state watchdog for the arbiter's master port.
//   clk, reset_n  : clock, asynchronous active-low reset
//   clr_i         : clear the stall counter (transfer finished or aborted)
//   inc_i         : one more stalled cycle on the granted transfer
//   timeout_o     : counter has reached TIMEOUT_CYCLES
//   bus_error_o   : sticky flag, set when a stalled transfer is aborted
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic timeout_o,
   output logic bus_error_o
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   assign timeout_o   = (cnt_q == LIMIT);
   assign bus_error_o = err_q;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
      // A stall seen while already at the limit is the abort cycle.
      if (inc_i && timeout_o) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter merging the instruction-fetch and data clients onto
// one Avalon-style memory master with registered master-side outputs.
//   clk, reset_n                      : clock, asynchronous active-low reset
//   i_address/i_read                  : instruction client request
//   i_waitrequest/i_readdata          : instruction client response
//   d_address/d_read/d_write/
//   d_writedata/d_byteenable          : data client request
//   d_waitrequest/d_readdata          : data client response
//   m_address/m_read/m_write/
//   m_writedata/m_byteenable          : registered master strobes to memory
//   m_waitrequest/m_readdata          : memory response
//   bus_error                         : sticky watchdog abort flag
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [31:0] m_writedata,
   output logic [3:0]  m_byteenable,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic        bus_error
);

   arb_state_t  state_q, state_d;
   grant_t      last_grant_q, last_grant_d;
   logic [31:0] m_address_q, m_address_d;
   logic        m_read_q, m_read_d;
   logic        m_write_q, m_write_d;
   logic [31:0] m_writedata_q, m_writedata_d;
   logic [3:0]  m_byteenable_q, m_byteenable_d;

   logic i_req, d_req, pick_data;
   logic granted, done, abort, finish, wd_timeout;

   assign i_req     = i_read;
   assign d_req     = d_read | d_write;
   // Data wins when it is the only requester or when instr went last.
   assign pick_data = d_req & (~i_req | (last_grant_q == INSTR));

   assign granted = (state_q != IDLE);
   assign done    = granted & ~m_waitrequest;
   assign abort   = granted & m_waitrequest & wd_timeout;
   assign finish  = done | abort;

   assign m_address    = m_address_q;
   assign m_read       = m_read_q;
   assign m_write      = m_write_q;
   assign m_writedata  = m_writedata_q;
   assign m_byteenable = m_byteenable_q;

   bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_watchdog (
      .clk         (clk),
      .reset_n     (reset_n),
      .clr_i       (finish),
      .inc_i       (granted & m_waitrequest),
      .timeout_o   (wd_timeout),
      .bus_error_o (bus_error)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         last_grant_q   <= INSTR;
         m_address_q    <= '0;
         m_read_q       <= 1'b0;
         m_write_q      <= 1'b0;
         m_writedata_q  <= '0;
         m_byteenable_q <= '0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         m_address_q    <= m_address_d;
         m_read_q       <= m_read_d;
         m_write_q      <= m_write_d;
         m_writedata_q  <= m_writedata_d;
         m_byteenable_q <= m_byteenable_d;
      end
   end

   // Next state, including the master-side capture at grant time.
   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      m_address_d    = m_address_q;
      m_read_d       = m_read_q;
      m_write_d      = m_write_q;
      m_writedata_d  = m_writedata_q;
      m_byteenable_d = m_byteenable_q;
      unique case (state_q)
         IDLE: begin
            if (pick_data) begin
               state_d        = GRANT_D;
               last_grant_d   = DATA;
               m_address_d    = d_address;
               m_write_d      = d_write;
               // Simultaneous read+write: the write goes out, the read is dropped.
               m_read_d       = ~d_write;
               m_writedata_d  = d_writedata;
               m_byteenable_d = d_byteenable;
            end else if (i_req) begin
               state_d        = GRANT_I;
               last_grant_d   = INSTR;
               m_address_d    = i_address;
               m_read_d       = 1'b1;
               m_write_d      = 1'b0;
               m_writedata_d  = '0;
               m_byteenable_d = '1;
            end
         end
         GRANT_I, GRANT_D: begin
            if (finish) begin
               state_d   = IDLE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Client responses are combinational in the completing cycle.
   always_comb begin
      i_waitrequest = i_req;
      d_waitrequest = d_req;
      i_readdata    = '0;
      d_readdata    = '0;
      if ((state_q == GRANT_I) && finish) begin
         i_waitrequest = 1'b0;
         i_readdata    = done ? m_readdata : ABORT_RDATA;
      end
      if ((state_q == GRANT_D) && finish) begin
         d_waitrequest = 1'b0;
         d_readdata    = done ? m_readdata : ABORT_RDATA;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed client requests push expected
// completions (client, data, cycle); a negedge monitor pops and compares.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] i_address;
   logic        i_read;
   logic        i_waitrequest;
   logic [31:0] i_readdata;
   logic [31:0] d_address;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteenable;
   logic        d_waitrequest;
   logic [31:0] d_readdata;
   logic [31:0] m_address;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic        m_waitrequest;
   logic [31:0] m_readdata;
   logic        bus_error;

   bus_arbiter #(
      .TIMEOUT_CYCLES (64),
      .CNT_W          (7)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_address     (i_address),
      .i_read        (i_read),
      .i_waitrequest (i_waitrequest),
      .i_readdata    (i_readdata),
      .d_address     (d_address),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_writedata   (d_writedata),
      .d_byteenable  (d_byteenable),
      .d_waitrequest (d_waitrequest),
      .d_readdata    (d_readdata),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_byteenable  (m_byteenable),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .bus_error     (bus_error)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory stub: waitrequest for one cycle plus num_stalls per transfer.
   logic [31:0] mem [256];
   logic [3:0]  num_stalls;
   logic        hang;
   logic [4:0]  scnt = '0;
   logic        ready;

   assign ready         = (m_read | m_write) && (scnt > {1'b0, num_stalls});
   assign m_waitrequest = hang | ~ready;
   assign m_readdata    = m_read ? mem[m_address[9:2]] : 32'h0;

   always @(posedge clk) begin
      if (!(m_read | m_write)) begin
         scnt <= '0;
      end else if (!m_waitrequest) begin
         scnt <= '0;
         if (m_write) begin
            for (int b = 0; b < 4; b++)
               if (m_byteenable[b]) mem[m_address[9:2]][b*8 +: 8] <= m_writedata[b*8 +: 8];
         end
      end else if (scnt != 5'h1f) begin
         scnt <= scnt + 1'b1;
      end
   end

   typedef struct {
      bit          is_data;
      logic [31:0] data;
      int unsigned at;
   } exp_t;

   exp_t sb[$];
   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit is_data, input logic [31:0] data, input int unsigned at);
      exp_t e;
      e.is_data = is_data;
      e.data    = data;
      e.at      = at;
      sb.push_back(e);
   endtask

   task automatic complete(input bit is_data, input logic [31:0] rd);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_completion: got client %0d data %h, expected none (cycle %0d)",
                  is_data, rd, cyc);
      end else begin
         e = sb.pop_front();
         chk("cpl_client", {31'b0, is_data}, {31'b0, e.is_data});
         chk("cpl_data", rd, e.data);
         chk("cpl_cycle", cyc, e.at);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (i_read && !i_waitrequest) complete(1'b0, i_readdata);
         if ((d_read || d_write) && !d_waitrequest) complete(1'b1, d_readdata);
      end
   end

   task automatic to_pos(input int unsigned t);
      do begin
         @(posedge clk);
         #1;
      end while (cyc < t);
   endtask

   task automatic to_neg(input int unsigned t);
      do @(negedge clk); while (cyc < t);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got no finish, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      int unsigned n;
      for (int k = 0; k < 256; k++) mem[k] = 32'h0;
      mem[0]  = 32'h2402000A;   // 0xBFC00000
      mem[12] = 32'hDEADBEEF;   // 0x30
      reset_n = 1'b0; hang = 1'b0; num_stalls = 4'd0;
      i_address = '0; i_read = 1'b0;
      d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_byteenable = '0;

      // Reset state
      to_neg(2);
      chk("rst_m_read", {31'b0, m_read}, 32'd0);
      chk("rst_m_write", {31'b0, m_write}, 32'd0);
      chk("rst_m_address", m_address, 32'h0);
      chk("rst_m_byteenable", {28'b0, m_byteenable}, 32'h0);
      chk("rst_bus_error", {31'b0, bus_error}, 32'd0);
      to_pos(3);
      reset_n = 1'b1;

      // Contention from reset: DATA, INSTR, DATA with one idle cycle between
      to_pos(cyc + 1); n = cyc;
      i_address = 32'hBFC00000; i_read = 1'b1;
      d_address = 32'h30; d_read = 1'b1; d_byteenable = 4'hF;
      push(1'b1, 32'hDEADBEEF, n + 2);
      push(1'b0, 32'h2402000A, n + 5);
      push(1'b1, 32'hDEADBEEF, n + 8);
      to_neg(n + 1); chk("tie_first_addr", m_address, 32'h30);
      to_neg(n + 3); chk("tie_gap1_m_read", {31'b0, m_read}, 32'd0);
      to_neg(n + 4); chk("tie_second_addr", m_address, 32'hBFC00000);
      to_neg(n + 6); chk("tie_gap2_m_read", {31'b0, m_read}, 32'd0);
      to_pos(n + 9); i_read = 1'b0; d_read = 1'b0;

      // Instruction-only read from the boot vector
      to_pos(cyc + 1); n = cyc;
      i_read = 1'b1;
      push(1'b0, 32'h2402000A, n + 2);
      to_neg(n);     chk("if_m_read_c0", {31'b0, m_read}, 32'd0);
      to_neg(n + 1); chk("if_m_read_c1", {31'b0, m_read}, 32'd1);
                     chk("if_m_address", m_address, 32'hBFC00000);
                     chk("if_m_byteenable", {28'b0, m_byteenable}, 32'hF);
      to_pos(n + 3); i_read = 1'b0;
      to_neg(n + 3); chk("if_m_read_c3", {31'b0, m_read}, 32'd0);

      // Partial write then 3-stall read back
      to_pos(cyc + 1); n = cyc;
      d_address = 32'h10; d_write = 1'b1; d_writedata = 32'hCAFEF00D; d_byteenable = 4'b0011;
      push(1'b1, 32'h0, n + 2);
      to_neg(n + 1); chk("wr_m_write", {31'b0, m_write}, 32'd1);
                     chk("wr_m_writedata", m_writedata, 32'hCAFEF00D);
                     chk("wr_m_byteenable", {28'b0, m_byteenable}, 32'h3);
      to_pos(n + 3); d_write = 1'b0;
      to_pos(cyc + 1); n = cyc;
      num_stalls = 4'd3; d_read = 1'b1; d_byteenable = 4'hF;
      push(1'b1, 32'h0000F00D, n + 5);
      to_neg(n + 4); chk("rd_wait_c4", {31'b0, d_waitrequest}, 32'd1);
      to_pos(n + 6); d_read = 1'b0;

      // Client address changes mid-transfer; master address holds
      to_pos(cyc + 1); n = cyc;
      d_address = 32'h10; d_read = 1'b1;
      push(1'b1, 32'h0000F00D, n + 5);
      to_pos(n + 2); d_address = 32'h20;
      to_neg(n + 2); chk("mid_m_address_c2", m_address, 32'h10);
      to_neg(n + 4); chk("mid_m_address_c4", m_address, 32'h10);
      to_pos(n + 6); d_read = 1'b0; num_stalls = 4'd0;

      // Simultaneous read+write: only the write goes out
      to_pos(cyc + 1); n = cyc;
      d_address = 32'h14; d_read = 1'b1; d_write = 1'b1; d_writedata = 32'h12345678;
      push(1'b1, 32'h0, n + 2);
      to_neg(n + 1); chk("rw_m_write", {31'b0, m_write}, 32'd1);
                     chk("rw_m_read", {31'b0, m_read}, 32'd0);
      to_pos(n + 3); d_read = 1'b0; d_write = 1'b0;
      to_pos(cyc + 1); n = cyc;
      d_read = 1'b1;
      push(1'b1, 32'h12345678, n + 2);
      to_pos(n + 3); d_read = 1'b0;

      // Watchdog: memory never completes
      to_pos(cyc + 1); n = cyc;
      hang = 1'b1; d_address = 32'h30; d_read = 1'b1;
      push(1'b1, 32'h0, n + 65);
      to_neg(n + 64); chk("wd_err_before", {31'b0, bus_error}, 32'd0);
                      chk("wd_wait_before", {31'b0, d_waitrequest}, 32'd1);
      to_pos(n + 66); d_read = 1'b0; hang = 1'b0;
      to_neg(n + 66); chk("wd_err_after", {31'b0, bus_error}, 32'd1);
                      chk("wd_m_read_dropped", {31'b0, m_read}, 32'd0);
      to_pos(cyc + 1); n = cyc;
      i_read = 1'b1;
      push(1'b0, 32'h2402000A, n + 2);
      to_pos(n + 3); i_read = 1'b0;
      to_neg(n + 3); chk("wd_err_sticky", {31'b0, bus_error}, 32'd1);

      // Reset while a write is on the bus
      to_pos(cyc + 1); n = cyc;
      num_stalls = 4'd10; d_address = 32'h40; d_write = 1'b1; d_writedata = 32'h11111111;
      to_neg(n + 1); chk("rstw_m_write_before", {31'b0, m_write}, 32'd1);
      to_pos(n + 2);
      #2 reset_n = 1'b0;
      #1;
      chk("rstw_m_write_async", {31'b0, m_write}, 32'd0);
      chk("rstw_m_address", m_address, 32'h0);
      chk("rstw_bus_error", {31'b0, bus_error}, 32'd0);
      d_write = 1'b0;
      to_pos(cyc + 2);
      reset_n = 1'b1; num_stalls = 4'd0;
      to_pos(cyc + 1); n = cyc;
      d_address = 32'h40; d_read = 1'b1;
      i_address = 32'hBFC00000; i_read = 1'b1;
      push(1'b1, 32'h0, n + 2);
      push(1'b0, 32'h2402000A, n + 5);
      to_pos(n + 6); d_read = 1'b0; i_read = 1'b0;

      to_pos(cyc + 3);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
